// File: rtl/jtbubl_shram_arb.sv
// rtl/jtbubl_shram_arb.sv - main/sub Z80 shared work-RAM arbiter with wait_n generation
// Define JTBUBL_SHRAM_FIXPRIO_EN for fixed main-first priority instead of round-robin.
module jtbubl_shram_arb #(
  parameter int AW  = 13,
  parameter int LAT = 1
) (
  input  logic          clk24,
  input  logic          rst_n,
  input  logic          main_cs,
  input  logic          main_wrn,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  output logic          main_wait_n,
  output logic [7:0]    main_q,
  input  logic          sub_cs,
  input  logic          sub_wrn,
  input  logic [AW-1:0] sub_addr,
  input  logic [7:0]    sub_dout,
  input  logic          sub_en,
  output logic          sub_wait_n,
  output logic [7:0]    sub_q,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_q
);

  localparam int            CW      = $clog2(LAT + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_M = 2'd1,
    GNT_S = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr_hold;
  logic [7:0]    r_din_hold;
  logic [7:0]    r_main_q;
  logic [7:0]    r_sub_q;
  logic          w_mreq;
  logic          w_sreq;
  logic          w_pick_main;
  logic          w_enter;

  assign w_mreq = main_cs;
  assign w_sreq = sub_cs & sub_en;

`ifdef JTBUBL_SHRAM_FIXPRIO_EN
  assign w_pick_main = 1'b1;
`else
  logic r_last;  // 1 = sub held the most recent grant
  assign w_pick_main = r_last;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_mreq && w_sreq) w_next = w_pick_main ? GNT_M : GNT_S;
        else if (w_mreq)      w_next = GNT_M;
        else if (w_sreq)      w_next = GNT_S;
      end
      GNT_M: if (!w_mreq) w_next = w_sreq ? GNT_S : IDLE;
      GNT_S: if (!w_sreq) w_next = w_mreq ? GNT_M : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handover goes straight from one grant to the other, so entry is any change into a grant state
  assign w_enter = (w_next != r_state) && (w_next != IDLE);

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_enter || w_next == IDLE) r_cnt <= '0;
      else if (r_cnt != CNT_MAX)     r_cnt <= r_cnt + 1'b1;
    end
  end

`ifndef JTBUBL_SHRAM_FIXPRIO_EN
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n)       r_last <= 1'b1;
    else if (w_enter) r_last <= (w_next == GNT_S);
  end
`endif

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_hold <= '0;
      r_din_hold  <= '0;
      r_main_q    <= '0;
      r_sub_q     <= '0;
    end else begin
      if (r_state == GNT_M) begin
        r_addr_hold <= main_addr;
        r_din_hold  <= main_dout;
        r_main_q    <= ram_q;
      end
      if (r_state == GNT_S) begin
        r_addr_hold <= sub_addr;
        r_din_hold  <= sub_dout;
        r_sub_q     <= ram_q;
      end
    end
  end

  always_comb begin
    ram_addr = r_addr_hold;
    ram_din  = r_din_hold;
    ram_we   = 1'b0;
    case (r_state)
      GNT_M: begin
        ram_addr = main_addr;
        ram_din  = main_dout;
        ram_we   = ~main_wrn;
      end
      GNT_S: begin
        ram_addr = sub_addr;
        ram_din  = sub_dout;
        ram_we   = ~sub_wrn & sub_en;
      end
      default: ram_we = 1'b0;
    endcase
  end

  assign main_q      = r_main_q;
  assign sub_q       = r_sub_q;
  assign main_wait_n = ~w_mreq | ((r_state == GNT_M) && (r_cnt == CNT_MAX));
  assign sub_wait_n  = ~w_sreq | ((r_state == GNT_S) && (r_cnt == CNT_MAX));

endmodule

// File: tb/tb_jtbubl_shram_arb.sv
// tb/tb_jtbubl_shram_arb.sv - scoreboard bench for jtbubl_shram_arb (LAT=1 and LAT=2 instances)
module tb_jtbubl_shram_arb;

  typedef struct {
    logic       rd;
    logic [7:0] d;
    int         lo;
  } exp_t;

  logic        clk24;
  logic        rst_n;
  logic        main_cs, main_wrn, sub_cs, sub_wrn, sub_en;
  logic [12:0] main_addr, sub_addr;
  logic [7:0]  main_dout, sub_dout;
  logic        main_wait_n, sub_wait_n, ram_we;
  logic [7:0]  main_q, sub_q, ram_din, ram_q;
  logic [12:0] ram_addr;

  logic        m2_cs, m2_wrn, m2_wait_n, s2_wait_n, ram_we2;
  logic [12:0] m2_addr, ram_addr2;
  logic [7:0]  m2_dout, m2_q, s2_q, ram_din2, ram_q2;

  logic        pre_we1, pre_we2;
  logic [12:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  mem1 [0:8191];
  logic [7:0]  mem2 [0:8191];
  logic [7:0]  q1, q2a, q2b;

  exp_t exp_m[$];
  exp_t exp_s[$];
  exp_t exp_m2[$];
  int   n_tests, n_fail, we_cnt, w0;

  jtbubl_shram_arb #(.AW(13), .LAT(1)) dut (
    .clk24(clk24), .rst_n(rst_n),
    .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr), .main_dout(main_dout),
    .main_wait_n(main_wait_n), .main_q(main_q),
    .sub_cs(sub_cs), .sub_wrn(sub_wrn), .sub_addr(sub_addr), .sub_dout(sub_dout),
    .sub_en(sub_en), .sub_wait_n(sub_wait_n), .sub_q(sub_q),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
  );

  jtbubl_shram_arb #(.AW(13), .LAT(2)) dut2 (
    .clk24(clk24), .rst_n(rst_n),
    .main_cs(m2_cs), .main_wrn(m2_wrn), .main_addr(m2_addr), .main_dout(m2_dout),
    .main_wait_n(m2_wait_n), .main_q(m2_q),
    .sub_cs(1'b0), .sub_wrn(1'b1), .sub_addr(13'd0), .sub_dout(8'd0),
    .sub_en(1'b0), .sub_wait_n(s2_wait_n), .sub_q(s2_q),
    .ram_addr(ram_addr2), .ram_din(ram_din2), .ram_we(ram_we2), .ram_q(ram_q2)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  always @(posedge clk24) begin
    if (pre_we1)     mem1[pre_a]    <= pre_d;
    else if (ram_we) mem1[ram_addr] <= ram_din;
    q1 <= mem1[ram_addr];
  end
  assign ram_q = q1;

  always @(posedge clk24) begin
    if (pre_we2)      mem2[pre_a]     <= pre_d;
    else if (ram_we2) mem2[ram_addr2] <= ram_din2;
    q2a <= mem2[ram_addr2];
    q2b <= q2a;
  end
  assign ram_q2 = q2b;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic int st();
    return int'(dut.r_state);
  endfunction

  task automatic push(input int p, input logic rd, input logic [7:0] d, input int lo);
    exp_t e;
    e.rd = rd; e.d = d; e.lo = lo;
    if (p == 0)      exp_m.push_back(e);
    else if (p == 1) exp_s.push_back(e);
    else             exp_m2.push_back(e);
  endtask

  task automatic score(input string nm, input exp_t e, input int lo, input logic [7:0] q);
    chk({nm, " wait cycles"}, lo, e.lo);
    if (e.rd) chk({nm, " read data"}, q, e.d);
  endtask

  task automatic preload(input int which, input logic [12:0] a, input logic [7:0] d);
    @(posedge clk24); #1;
    pre_a = a; pre_d = d;
    if (which == 1) pre_we1 = 1'b1; else pre_we2 = 1'b1;
    @(posedge clk24); #1;
    pre_we1 = 1'b0; pre_we2 = 1'b0;
  endtask

  // p: 0 = main, 1 = sub (LAT=1 instance), 2 = main of LAT=2 instance
  task automatic access(input int p, input logic [12:0] a, input logic wr, input logic [7:0] d);
    logic ok, wn;
    @(posedge clk24); #1;
    case (p)
      0: begin main_cs = 1'b1; main_wrn = ~wr; main_addr = a; main_dout = d; end
      1: begin sub_cs  = 1'b1; sub_wrn  = ~wr; sub_addr  = a; sub_dout  = d; end
      default: begin m2_cs = 1'b1; m2_wrn = ~wr; m2_addr = a; m2_dout = d; end
    endcase
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk24);
      wn = (p == 0) ? main_wait_n : (p == 1) ? sub_wait_n : m2_wait_n;
      if (wn) begin ok = 1'b1; break; end
    end
    if (!ok) chk($sformatf("wait_n timeout port %0d", p), 0, 1);
    @(posedge clk24); #1;
    case (p)
      0: begin main_cs = 1'b0; main_wrn = 1'b1; end
      1: begin sub_cs  = 1'b0; sub_wrn  = 1'b1; end
      default: begin m2_cs = 1'b0; m2_wrn = 1'b1; end
    endcase
  endtask

  task automatic handover_chk();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk24);
      if (main_cs) seen = 1'b1;
      else if (seen) break;
    end
    @(posedge clk24); @(negedge clk24);
    chk("t3 handover state", st(), 2);
    chk("t3 sub still waiting", sub_wait_n, 0);
  endtask

  initial forever begin
    @(negedge clk24);
    if (ram_we) we_cnt++;
  end

  initial begin : mon_main
    int lo; logic done; exp_t e;
    lo = 0; done = 1'b0;
    forever begin
      @(negedge clk24);
      if (!main_cs) begin lo = 0; done = 1'b0; end
      else if (!done) begin
        if (main_wait_n) begin
          done = 1'b1;
          chk("main expected pending", exp_m.size(), 1);
          if (exp_m.size() > 0) begin e = exp_m.pop_front(); score("main", e, lo, main_q); end
        end else lo++;
      end
    end
  end

  initial begin : mon_sub
    int lo; logic done; exp_t e;
    lo = 0; done = 1'b0;
    forever begin
      @(negedge clk24);
      if (!sub_cs) begin lo = 0; done = 1'b0; end
      else if (!done) begin
        if (sub_wait_n) begin
          done = 1'b1;
          chk("sub expected pending", exp_s.size(), 1);
          if (exp_s.size() > 0) begin e = exp_s.pop_front(); score("sub", e, lo, sub_q); end
        end else lo++;
      end
    end
  end

  initial begin : mon_main2
    int lo; logic done; exp_t e;
    lo = 0; done = 1'b0;
    forever begin
      @(negedge clk24);
      if (!m2_cs) begin lo = 0; done = 1'b0; end
      else if (!done) begin
        if (m2_wait_n) begin
          done = 1'b1;
          chk("lat2 expected pending", exp_m2.size(), 1);
          if (exp_m2.size() > 0) begin e = exp_m2.pop_front(); score("lat2 main", e, lo, m2_q); end
        end else lo++;
      end
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; we_cnt = 0;
    rst_n = 1'b0;
    main_cs = 1'b0; main_wrn = 1'b1; main_addr = '0; main_dout = '0;
    sub_cs  = 1'b0; sub_wrn  = 1'b1; sub_addr  = '0; sub_dout  = '0; sub_en = 1'b1;
    m2_cs   = 1'b0; m2_wrn   = 1'b1; m2_addr   = '0; m2_dout   = '0;
    pre_we1 = 1'b0; pre_we2 = 1'b0; pre_a = '0; pre_d = '0;

    repeat (3) @(posedge clk24);
    @(negedge clk24);
    chk("reset state", st(), 0);
    chk("reset ram_we", ram_we, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_din", ram_din, 0);
    chk("reset main_q", main_q, 0);
    chk("reset sub_q", sub_q, 0);
    chk("reset main_wait_n", main_wait_n, 1);
    chk("reset sub_wait_n", sub_wait_n, 1);
    chk("reset lat2 ram_din", ram_din2, 0);
    chk("reset lat2 sub_wait_n", s2_wait_n, 1);
    @(posedge clk24); #1 rst_n = 1'b1;

    preload(1, 13'h0123, 8'h5A);
    preload(1, 13'h0010, 8'h3C);
    preload(1, 13'h0200, 8'h11);
    preload(1, 13'h0300, 8'h44);
    preload(2, 13'h0ABC, 8'hC3);

    // main-only read
    w0 = we_cnt;
    push(0, 1'b1, 8'h5A, 3);
    access(0, 13'h0123, 1'b0, 8'h00);
    chk("t1 no ram write", we_cnt - w0, 0);

    // sub write then main read of the same word
    w0 = we_cnt;
    push(1, 1'b0, 8'h00, 3);
    access(1, 13'h1FFF, 1'b1, 8'hA5);
    chk("t2 ram_we cycles", we_cnt - w0, 3);
    push(0, 1'b1, 8'hA5, 3);
    access(0, 13'h1FFF, 1'b0, 8'h00);
    chk("t2 ram content", mem1[13'h1FFF], 8'hA5);

    // simultaneous requests straight after reset
    @(posedge clk24); #1 rst_n = 1'b0;
    @(posedge clk24); #1 rst_n = 1'b1;
    push(0, 1'b1, 8'h5A, 3);
    push(1, 1'b1, 8'h3C, 7);
    fork
      access(0, 13'h0123, 1'b0, 8'h00);
      access(1, 13'h0010, 1'b0, 8'h00);
      handover_chk();
    join
    push(0, 1'b1, 8'h5A, 3);
    access(0, 13'h0123, 1'b0, 8'h00);
`ifdef JTBUBL_SHRAM_FIXPRIO_EN
    push(0, 1'b1, 8'h5A, 3);
    push(1, 1'b1, 8'h3C, 7);
`else
    push(0, 1'b1, 8'h5A, 7);
    push(1, 1'b1, 8'h3C, 3);
`endif
    fork
      access(0, 13'h0123, 1'b0, 8'h00);
      access(1, 13'h0010, 1'b0, 8'h00);
    join

    // sub write aborted by sub_en falling on the first grant cycle
    push(1, 1'b0, 8'h00, 1);
    @(posedge clk24); #1;
    sub_cs = 1'b1; sub_wrn = 1'b0; sub_addr = 13'h0200; sub_dout = 8'h77;
    @(posedge clk24); #1 sub_en = 1'b0;
    @(negedge clk24);
    chk("t4 ram_we masked", ram_we, 0);
    chk("t4 sub_wait_n masked", sub_wait_n, 1);
    @(posedge clk24); @(negedge clk24);
    chk("t4 state idle", st(), 0);
    @(posedge clk24); #1;
    sub_cs = 1'b0; sub_wrn = 1'b1; sub_en = 1'b1;
    repeat (2) @(posedge clk24);
    chk("t4 ram unchanged", mem1[13'h0200], 8'h11);

    // asynchronous reset in the middle of a main write grant
    @(posedge clk24); #1;
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 13'h0300; main_dout = 8'h99;
    @(posedge clk24); #3;
    chk("t5 main_q before reset", main_q, 8'h5A);
    chk("t5 ram_we before reset", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("t5 state after reset", st(), 0);
    chk("t5 ram_we after reset", ram_we, 0);
    chk("t5 main_q after reset", main_q, 0);
    @(posedge clk24); #1;
    main_cs = 1'b0; main_wrn = 1'b1;
    repeat (2) @(posedge clk24);
    #1 rst_n = 1'b1;
    chk("t5 ram unchanged", mem1[13'h0300], 8'h44);

    // LAT=2 instance read
    push(2, 1'b1, 8'hC3, 4);
    access(2, 13'h0ABC, 1'b0, 8'h00);

    repeat (5) @(posedge clk24);
    chk("main queue drained", exp_m.size(), 0);
    chk("sub queue drained", exp_s.size(), 0);
    chk("lat2 queue drained", exp_m2.size(), 0);
    chk("lat2 sub_q idle", s2_q, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
